input_port_ctrl: RTL

- Front end for the CPU's 8-bit `inputSignal` port: the transmit side of the operand-input interface that the CPU reads.
- Synchronizes and debounces the raw board switches and the load push-button.
- On each debounced button press, it presents one captured byte to the CPU with a valid/ack handshake.
- Flags a sticky overrun if a new press arrives before the CPU has consumed the previous byte.

---
 rtl/input_port_pkg.sv | 12 +
 rtl/sync_debounce.sv | 69 ++++++
 rtl/input_port_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/input_port_pkg.sv
// Shared types and defaults for the CPU operand-input front end.
package input_port_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } in_state_t;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEBOUNCE = 4;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a counter debouncer; the whole vector
// is treated as one unit so a multi-bit change is accepted atomically.
module sync_debounce #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL         = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_raw,
  output logic [WIDTH-1:0] d_stable
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_w;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        meta_q <= RST_VAL[gi];
        sync_q <= RST_VAL[gi];
      end else begin
        meta_q <= d_raw[gi];
        sync_q <= meta_q;
      end
    end

    assign sync_w[gi] = sync_q;
  end

  logic [WIDTH-1:0] cand_q,   cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Counter saturates at CNT_MAX so a long-held value keeps re-writing stable.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_w != cand_q) begin
      cand_d = sync_w;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cand_q   <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign d_stable = stable_q;

endmodule

// File: rtl/input_port_ctrl.sv
// Switch/button front end for the CPU inputSignal port: debounced capture of
// one byte per button press, valid/ack handshake and sticky overrun flag.
module input_port_ctrl
  import input_port_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             key_n,
  output logic [WIDTH-1:0] stable_sw,
  output logic [WIDTH-1:0] in_data,
  output logic             in_valid,
  input  logic             in_ack,
  output logic             overrun
);

  logic [WIDTH-1:0] sw_stable_w;
  logic             key_stable_w;

  sync_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_VAL         ({WIDTH{1'b0}})
  ) u_sw_db (
    .clk      (clk),
    .rstn     (rstn),
    .d_raw    (sw_in),
    .d_stable (sw_stable_w)
  );

  // Key idles high (active-low button), so its pipeline resets to 1.
  sync_debounce #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RST_VAL         (1'b1)
  ) u_key_db (
    .clk      (clk),
    .rstn     (rstn),
    .d_raw    (key_n),
    .d_stable (key_stable_w)
  );

  logic             key_prev_q;
  logic             press_w;
  in_state_t        state_q;
  logic [WIDTH-1:0] in_data_q;
  logic             in_valid_q;
  logic             overrun_q;

  assign press_w = key_prev_q & ~key_stable_w;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      key_prev_q <= 1'b1;
      state_q    <= IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      key_prev_q <= key_stable_w;
      case (state_q)
        IDLE: begin
          if (press_w) begin
            in_data_q  <= sw_stable_w;
            in_valid_q <= 1'b1;
            state_q    <= VALID;
          end
        end
        VALID: begin
          // A press coinciding with ack replaces the byte instead of dropping it.
          if (press_w) begin
            if (in_ack) begin
              in_data_q <= sw_stable_w;
            end else begin
              overrun_q <= 1'b1;
            end
          end else if (in_ack) begin
            in_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign stable_sw = sw_stable_w;
  assign in_data   = in_data_q;
  assign in_valid  = in_valid_q;
  assign overrun   = overrun_q;

endmodule
